pipe_hazard_sequencer: RTL and testbench
========================================

Name: pipe_hazard_sequencer

Overview:
Central pipeline controller for the 5-stage processor. It arbitrates four stall/flush sources: multi-cycle data-memory wait, taken branch, load-use hazard and external interrupt. From these it drives per-stage register enables and bubble/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also counts lost fetch cycles for performance debug.

Parameters:
REG_W, 3, register-index width
DRAIN_CYCLES, 3, bubble-insertion cycles before interrupt entry (1..7)
MEM_TIMEOUT, 15, max consecutive MEM_WAIT cycles before memory error (1..255)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
hz_enable  in  1  load-use detection enable
id_ex_mem_read  in  1  instruction in EX is a load
id_ex_rd  in  REG_W  destination of the load in EX
if_id_rs1, if_id_rs2  in  REG_W  sources of the instruction in ID
if_id_use_rs1, if_id_use_rs2  in  1  the source is actually read
branch_taken  in  1  taken branch resolved in EX (level, one cycle per branch)
mem_busy  in  1  data memory not ready (level)
int_req  in  1  interrupt request (level, held until int_ack)
pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  stage register load enables
if_id_flush  out  1  IF/ID loads a NOP
id_ex_bubble  out  1  ID/EX loads a NOP
mem_wb_bubble  out  1  MEM/WB loads a NOP
int_ack  out  1  one-cycle interrupt-entry strobe
mem_err  out  1  one-cycle memory-timeout strobe
stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0
state_dbg  out  3  current state encoding

Behaviour:
- States: RUN=0, LOAD_STALL=1, MEM_WAIT=2, INT_DRAIN=3, INT_ENTER=4. Any other encoding goes to RUN with RUN outputs.
- Outputs are combinational from state and inputs. State, drain counter, timeout counter and stall_cnt are registered.
- rst asserted (asynchronous): state=RUN, counters=0. While rst is high, all enables=0, all flush/bubble=0, int_ack=0, mem_err=0, stall_cnt=0.
- Default outputs: all enables=1, all flush/bubble/strobes=0.
- Load-use hazard: hz = hz_enable & id_ex_mem_read & ((if_id_use_rs1 & rs1==rd) | (if_id_use_rs2 & rs2==rd)).
- RUN, with fixed priority mem_busy > branch_taken > hz > int_req:
  - mem_busy: pc_en, if_id_en, id_ex_en, ex_mem_en =0; mem_wb_bubble=1; timeout counter=1; next MEM_WAIT.
  - branch_taken: if_id_flush=1, id_ex_bubble=1; next RUN.
  - hz: pc_en=0, if_id_en=0, id_ex_bubble=1; next LOAD_STALL.
  - int_req: pc_en=0, if_id_flush=1; drain counter=1; next INT_DRAIN. If DRAIN_CYCLES=1, next INT_ENTER instead.
  - none: default outputs; stay in RUN.
- LOAD_STALL: exactly one cycle. hz is ignored. mem_busy takes priority (same actions as in RUN, next MEM_WAIT). branch_taken gives the flush outputs. Otherwise default outputs. Next RUN.
- MEM_WAIT: freeze outputs as on entry while mem_busy=1, and the timeout counter increments.
  - mem_busy=0: default outputs; next RUN. A branch_taken in this cycle is honoured (flush outputs).
  - Counter reaches MEM_TIMEOUT while still busy: mem_err=1 for that cycle; next RUN; the counter clears.
  - The interrupt return state is not tracked. A pending int_req is re-evaluated in RUN.
- INT_DRAIN: pc_en=0, if_id_flush=1.
  - mem_busy=1: full freeze and the drain counter holds (no MEM_WAIT transition). The timeout is not checked here.
  - branch_taken: id_ex_bubble=1 additionally.
  - hz is ignored.
  - The drain counter increments on non-busy cycles. When it reaches DRAIN_CYCLES, next INT_ENTER.
- INT_ENTER: int_ack=1, pc_en=1 (PC loads the vector externally), if_id_flush=1; next RUN.
  - If mem_busy=1, hold INT_ENTER with the full freeze and int_ack=0; ack only on the first non-busy cycle.
- int_req deasserting during INT_DRAIN does not abort the drain. Entry completes.
- stall_cnt increments on every cycle where pc_en=0 and rst=0. It saturates at all-ones, with no wrap.

Test Plan:
- Reset: hold rst 3 cycles, release mid-cycle -> all outputs 0 while rst=1; first cycle after release state_dbg=0, all enables=1, stall_cnt=0.
- Load-use: id_ex_mem_read=1, rd=3, rs2=3, use_rs2=1 held 2 cycles -> cycle 1: pc_en=0, if_id_en=0, id_ex_bubble=1, state→1; cycle 2: defaults, state→0; stall_cnt=1.
- Priority: mem_busy, branch_taken and hz all high in RUN -> freeze plus mem_wb_bubble only, no flush; mem_busy drops after 4 cycles with branch_taken=1 -> that cycle if_id_flush=1, id_ex_bubble=1.
- Timeout: MEM_TIMEOUT=15, mem_busy stuck high -> mem_err pulses exactly once, 15 cycles after entry; state returns to 0.
- Interrupt: int_req=1 with DRAIN_CYCLES=3 -> 3 cycles of pc_en=0/if_id_flush=1, then one cycle of int_ack=1/pc_en=1; insert mem_busy for 2 cycles mid-drain -> ack delayed by 2 cycles.
- Saturation: CNT_W=4, 20 stall cycles -> stall_cnt stops at 15.

Source files
------------

// File: rtl/pipe_hazard_sequencer.sv
`default_nettype none
// ============================================================================
// pipe_hazard_sequencer - stall/flush arbiter for the 5-stage pipeline
// Rev 1.0
// ============================================================================
module pipe_hazard_sequencer #(
  parameter int REG_W        = 3,
  parameter int DRAIN_CYCLES = 3,
  parameter int MEM_TIMEOUT  = 15,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hz_enable,
  input  logic             id_ex_mem_read,
  input  logic [REG_W-1:0] id_ex_rd,
  input  logic [REG_W-1:0] if_id_rs1,
  input  logic [REG_W-1:0] if_id_rs2,
  input  logic             if_id_use_rs1,
  input  logic             if_id_use_rs2,
  input  logic             branch_taken,
  input  logic             mem_busy,
  input  logic             int_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             mem_wb_bubble,
  output logic             int_ack,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_RUN        = 3'd0,
    S_LOAD_STALL = 3'd1,
    S_MEM_WAIT   = 3'd2,
    S_INT_DRAIN  = 3'd3,
    S_INT_ENTER  = 3'd4
  } state_t;

  localparam logic [3:0] DRAIN_TGT   = 4'(DRAIN_CYCLES);
  localparam logic [7:0] TIMEOUT_TGT = 8'(MEM_TIMEOUT);

  state_t           state, state_nxt;
  logic [2:0]       drain_cnt, drain_nxt;
  logic [7:0]       to_cnt, to_nxt;
  logic [CNT_W-1:0] stall_q;
  logic             hz;
  logic             pc_r, ifid_r, idex_r, exmem_r, memwb_r;
  logic             flush_r, bubble_r, wbbub_r, ack_r, err_r;

  assign hz = hz_enable & id_ex_mem_read &
              ((if_id_use_rs1 & (if_id_rs1 == id_ex_rd)) |
               (if_id_use_rs2 & (if_id_rs2 == id_ex_rd)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_RUN;
      drain_cnt <= 3'd0;
      to_cnt    <= 8'd0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      to_cnt    <= to_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    drain_nxt = drain_cnt;
    to_nxt    = to_cnt;
    pc_r      = 1'b1;
    ifid_r    = 1'b1;
    idex_r    = 1'b1;
    exmem_r   = 1'b1;
    memwb_r   = 1'b1;
    flush_r   = 1'b0;
    bubble_r  = 1'b0;
    wbbub_r   = 1'b0;
    ack_r     = 1'b0;
    err_r     = 1'b0;
    case (state)
      S_LOAD_STALL: begin
        state_nxt = S_RUN;
        if (mem_busy) begin
          {pc_r, ifid_r, idex_r, exmem_r} = 4'b0000;
          wbbub_r   = 1'b1;
          to_nxt    = 8'd1;
          state_nxt = S_MEM_WAIT;
        end else if (branch_taken) begin
          flush_r  = 1'b1;
          bubble_r = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (mem_busy) begin
          {pc_r, ifid_r, idex_r, exmem_r} = 4'b0000;
          wbbub_r = 1'b1;
          if (to_cnt >= TIMEOUT_TGT) begin
            err_r     = 1'b1;
            to_nxt    = 8'd0;
            state_nxt = S_RUN;
          end else begin
            to_nxt = to_cnt + 8'd1;
          end
        end else begin
          to_nxt    = 8'd0;
          state_nxt = S_RUN;
          flush_r   = branch_taken;
          bubble_r  = branch_taken;
        end
      end
      S_INT_DRAIN: begin
        // A busy memory freezes the whole pipe; the drain simply pauses.
        if (mem_busy) begin
          {pc_r, ifid_r, idex_r, exmem_r, memwb_r} = 5'b00000;
        end else begin
          pc_r     = 1'b0;
          flush_r  = 1'b1;
          bubble_r = branch_taken;
          if (({1'b0, drain_cnt} + 4'd1) >= DRAIN_TGT) begin
            drain_nxt = 3'd0;
            state_nxt = S_INT_ENTER;
          end else begin
            drain_nxt = drain_cnt + 3'd1;
          end
        end
      end
      S_INT_ENTER: begin
        if (mem_busy) begin
          {pc_r, ifid_r, idex_r, exmem_r, memwb_r} = 5'b00000;
        end else begin
          ack_r     = 1'b1;
          flush_r   = 1'b1;
          state_nxt = S_RUN;
        end
      end
      default: begin
        state_nxt = S_RUN;
        if (mem_busy) begin
          {pc_r, ifid_r, idex_r, exmem_r} = 4'b0000;
          wbbub_r   = 1'b1;
          to_nxt    = 8'd1;
          state_nxt = S_MEM_WAIT;
        end else if (branch_taken) begin
          flush_r  = 1'b1;
          bubble_r = 1'b1;
        end else if (hz) begin
          pc_r      = 1'b0;
          ifid_r    = 1'b0;
          bubble_r  = 1'b1;
          state_nxt = S_LOAD_STALL;
        end else if (int_req) begin
          pc_r    = 1'b0;
          flush_r = 1'b1;
          if (DRAIN_TGT <= 4'd1) begin
            drain_nxt = 3'd0;
            state_nxt = S_INT_ENTER;
          end else begin
            drain_nxt = 3'd1;
            state_nxt = S_INT_DRAIN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (!pc_r && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  // Reset forces every control low, including the otherwise-default enables.
  assign pc_en         = pc_r     & ~rst;
  assign if_id_en      = ifid_r   & ~rst;
  assign id_ex_en      = idex_r   & ~rst;
  assign ex_mem_en     = exmem_r  & ~rst;
  assign mem_wb_en     = memwb_r  & ~rst;
  assign if_id_flush   = flush_r  & ~rst;
  assign id_ex_bubble  = bubble_r & ~rst;
  assign mem_wb_bubble = wbbub_r  & ~rst;
  assign int_ack       = ack_r    & ~rst;
  assign mem_err       = err_r    & ~rst;
  assign stall_cnt     = stall_q;
  assign state_dbg     = state;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pipe_hazard_sequencer - directed + random checks against a cycle model
// Rev 1.0
// ============================================================================
module tb_pipe_hazard_sequencer;
  localparam int REG_W = 3;
  localparam int DRAIN = 3;
  localparam int TMO   = 15;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             hz_enable, id_ex_mem_read;
  logic [REG_W-1:0] id_ex_rd, if_id_rs1, if_id_rs2;
  logic             if_id_use_rs1, if_id_use_rs2, branch_taken, mem_busy, int_req;
  logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic             if_id_flush, id_ex_bubble, mem_wb_bubble, int_ack, mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [2:0]       state_dbg;
  logic [9:0]       obs;
  logic [9:0]       last_obs;

  int n_assert = 0;
  int n_fail   = 0;
  int m_st, m_drain, m_tmo, m_stall;

  pipe_hazard_sequencer #(
    .REG_W(REG_W), .DRAIN_CYCLES(DRAIN), .MEM_TIMEOUT(TMO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .hz_enable(hz_enable), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_rd(id_ex_rd), .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2),
    .branch_taken(branch_taken), .mem_busy(mem_busy), .int_req(int_req),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .mem_wb_bubble(mem_wb_bubble), .int_ack(int_ack), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .state_dbg(state_dbg)
  );

  assign obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_bubble, mem_wb_bubble, int_ack, mem_err};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Output vector order: {pc,if_id,id_ex,ex_mem,mem_wb,flush,bubble,wb_bubble,ack,err}
  function automatic void model(output logic [9:0] o, output int ns, output int nd,
                                output int nt);
    bit hz, pc, ifid, idex, exm, mwb, fl, bb, wb, ack, err;
    hz = hz_enable && id_ex_mem_read &&
         ((if_id_use_rs1 && (if_id_rs1 == id_ex_rd)) ||
          (if_id_use_rs2 && (if_id_rs2 == id_ex_rd)));
    {pc, ifid, idex, exm, mwb} = 5'b11111;
    {fl, bb, wb, ack, err}     = 5'b00000;
    ns = 0; nd = m_drain; nt = m_tmo;
    if (m_st == 0 || m_st == 1) begin
      if (mem_busy) begin
        {pc, ifid, idex, exm} = 4'b0000; wb = 1; nt = 1; ns = 2;
      end else if (branch_taken) begin
        fl = 1; bb = 1;
      end else if (m_st == 0 && hz) begin
        pc = 0; ifid = 0; bb = 1; ns = 1;
      end else if (m_st == 0 && int_req) begin
        pc = 0; fl = 1; nd = 1; ns = (DRAIN == 1) ? 4 : 3;
      end
    end else if (m_st == 2) begin
      if (!mem_busy) begin
        nt = 0; fl = branch_taken; bb = branch_taken;
      end else begin
        {pc, ifid, idex, exm} = 4'b0000; wb = 1;
        if (m_tmo >= TMO) begin err = 1; nt = 0; end
        else begin nt = m_tmo + 1; ns = 2; end
      end
    end else if (mem_busy) begin
      {pc, ifid, idex, exm, mwb} = 5'b00000; ns = m_st;
    end else if (m_st == 3) begin
      pc = 0; fl = 1; bb = branch_taken; nd = m_drain + 1; ns = (nd >= DRAIN) ? 4 : 3;
    end else begin
      ack = 1; fl = 1;
    end
    o = {pc, ifid, idex, exm, mwb, fl, bb, wb, ack, err};
  endfunction

  // Entered at posedge+1 with inputs already applied; leaves at next posedge+1.
  task automatic cycle();
    logic [9:0] eo;
    int ns, nd, nt;
    #3;
    model(eo, ns, nd, nt);
    last_obs = obs;
    chk("outs", obs, eo);
    chk("state", state_dbg, m_st);
    chk("stall", stall_cnt, m_stall);
    @(posedge clk);
    if (!eo[9] && m_stall < SAT) m_stall++;
    m_st = ns; m_drain = nd; m_tmo = nt;
    #1;
  endtask

  task automatic idle_inputs();
    hz_enable = 1'b1; id_ex_mem_read = 1'b0; id_ex_rd = '0; if_id_rs1 = '0;
    if_id_rs2 = '0; if_id_use_rs1 = 1'b0; if_id_use_rs2 = 1'b0;
    branch_taken = 1'b0; mem_busy = 1'b0; int_req = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_outs", obs, 10'b0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_state", state_dbg, 0);
    @(negedge clk);
    rst = 1'b0;
    m_st = 0; m_drain = 0; m_tmo = 0; m_stall = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ack_idx, err_idx, n_ack, n_err, pc0;
    idle_inputs();
    #1;

    do_reset();
    cycle();
    chk("rst_first_en", last_obs[9:5], 5'h1f);

    id_ex_mem_read = 1; id_ex_rd = 3'd3; if_id_rs2 = 3'd3; if_id_use_rs2 = 1;
    cycle();
    chk("lu_c1", last_obs, 10'b0011101000);
    cycle();
    chk("lu_c2", last_obs, 10'b1111100000);
    chk("lu_stall", stall_cnt, 1);

    mem_busy = 1; branch_taken = 1;
    cycle();
    chk("prio_entry", last_obs, 10'b0000100100);
    repeat (3) cycle();
    mem_busy = 0;
    cycle();
    chk("prio_exit_flush", last_obs, 10'b1111111000);
    idle_inputs();
    repeat (2) cycle();

    err_idx = -1; n_err = 0;
    mem_busy = 1;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (last_obs[0]) begin n_err++; if (err_idx < 0) err_idx = i; end
    end
    mem_busy = 0;
    cycle();
    chk("tmo_idx", err_idx, 15);
    chk("tmo_once", n_err, 1);
    chk("tmo_state", state_dbg, 0);

    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      ack_idx = -1; n_ack = 0; pc0 = 0;
      int_req = 1;
      for (int i = 0; i < 12; i++) begin
        mem_busy = (pass == 1) && (i == 1 || i == 2);
        cycle();
        if (!last_obs[9] && !mem_busy) pc0++;
        if (last_obs[1]) begin n_ack++; if (ack_idx < 0) ack_idx = i; int_req = 0; end
      end
      chk("int_ack_idx", ack_idx, (pass == 1) ? 5 : 3);
      chk("int_ack_once", n_ack, 1);
      chk("int_drain_cycles", pc0, 3);
    end

    do_reset();
    mem_busy = 1;
    repeat (20) cycle();
    chk("sat_stall", stall_cnt, 15);
    idle_inputs();
    cycle();

    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      hz_enable      = ($urandom_range(0, 7) != 0);
      id_ex_mem_read = ($urandom_range(0, 2) == 0);
      id_ex_rd       = REG_W'($urandom_range(0, 7));
      if_id_rs1      = REG_W'($urandom_range(0, 7));
      if_id_rs2      = REG_W'($urandom_range(0, 7));
      if_id_use_rs1  = $urandom_range(0, 1) == 1;
      if_id_use_rs2  = $urandom_range(0, 1) == 1;
      branch_taken   = ($urandom_range(0, 7) == 0);
      mem_busy       = ($urandom_range(0, 3) == 0);
      if (!int_req) int_req = ($urandom_range(0, 9) == 0);
      cycle();
      if (last_obs[1]) int_req = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
